tt_probe3: RTL
==============

Name: tt_probe3

Overview:
- Sequential truth-table reader for 3-input single-output logic blocks, such as the NOR/NOT gate netlists generated for hex truth tables like 0xF6.
- Drives all 8 input combinations into a device-under-probe (DUP), waits a settle time, samples the output twice, and assembles the 8-bit truth-table code.
- Compares the code against an expected value.
- Used in score-calculation benches and on-chip self-check to confirm that a synthesized netlist implements its target hex code.

Parameters:
- SETTLE, 4: cycles to wait after driving a row before the first sample. Legal range 3..255; minimum 3 covers the 2-flop output synchronizer.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a sweep; accepted only in IDLE
- expected  input  8  expected truth-table code; captured when start is accepted
- in1  output  1  DUP input 1 (row index MSB)
- in2  output  1  DUP input 2
- in3  output  1  DUP input 3 (row index LSB)
- out  input  1  DUP output; asynchronous to this block, so it is synchronized internally
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse at sweep end
- tt  output  8  measured truth-table code
- match  output  1  tt == captured expected; valid from done until next start
- unstable  output  1  at least one row had differing samples

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Deassertion is synchronized inside the block.
- Reset values: in1/in2/in3=0, busy=0, done=0, tt=0x00, match=0, unstable=0, state=IDLE, synchronizer flops=0.
- Row encoding: row r = {in1,in2,in3}, r=0..7. Code bit (7-r) holds the DUP output for row r, so row 0 maps to the MSB. Under this encoding, the function out = ~in1 | (in2^in3) yields 0xF6.
- out passes through a 2-flop synchronizer (out_s); all sampling uses out_s.
- FSM states: IDLE, SETTLE_W, SAMP_A, SAMP_B, DONE.
  - IDLE: in1..3 held at 0. On start=1:
    - capture expected;
    - clear tt, unstable, match;
    - row=0; busy=1; go to SETTLE_W.
  - SETTLE_W: row driven on in1..3; counter counts SETTLE cycles, then go to SAMP_A.
  - SAMP_A: a_bit <= out_s; go to SAMP_B.
  - SAMP_B:
    - tt[7-row] <= out_s;
    - if out_s != a_bit, unstable <= 1;
    - if row==7, go to DONE; else row++ and go to SETTLE_W.
  - DONE (1 cycle): done=1, match=(tt==expected), busy=0; go to IDLE.
- Latency: start accepted at edge E0 → done high during cycle E0+8*(SETTLE+2)+1. With SETTLE=4 this is 49.
- tt, match and unstable hold their values in IDLE until the next accepted start.
- While busy, in1..3 change only on SAMP_B→SETTLE_W transitions.
- Boundary conditions:
  - start while busy: ignored, with no restart and no queuing.
  - start held high continuously: a new sweep begins the cycle after DONE.
  - expected changing mid-sweep: no effect, because the value was captured at start.
  - rst_n asserted mid-sweep: all outputs return to reset values immediately and asynchronously, no done pulse is produced, and the partial tt is discarded.
  - Row counter is 3 bits; it never wraps within a sweep.
  - unstable does not alter the tt bit; the second sample wins.

Test Plan:
- Behavioural DUP out=~in1|(in2^in3), SETTLE=4, expected=0xF6, start pulse → 49 cycles later done pulse; tt=0xF6, match=1, unstable=0, busy low after done.
- Same DUP, expected=0x00 → tt=0xF6, match=0; then DUP out=in1&in2&in3 with a new start → tt=0x01.
- DUP stuck at 1 → tt=0xFF; DUP stuck at 0 → tt=0x00. In both cases the row sequence on in1..3 observed is 0,1,...,7, each held SETTLE+2 cycles.
- Force out to toggle between SAMP_A and SAMP_B on row 5 only → unstable=1; tt bit 2 equals the second sample; all other bits are correct.
- Pulse start again at cycle 10 of a sweep → ignored; a single done pulse at cycle 49; tt unchanged by the extra pulse.
- Assert rst_n low at cycle 20 → in1..3=0, busy=0, tt=0x00 asynchronously, and no done pulse. After release, a new start completes normally with tt=0xF6.

Source files
------------

// File: rtl/tt_probe3.sv
// Sequential truth-table reader for a 3-input, 1-output logic block: sweeps rows 0..7,
// double-samples the synchronized response and assembles the 8-bit code (row 0 -> MSB).
//
// state    | meaning
// IDLE     | waiting for start, DUP inputs held at 0
// SETTLE_W | current row driven, down-counter runs SETTLE cycles
// SAMP_A   | first sample of out_s
// SAMP_B   | second sample, stored into tt; advance row or finish
// DONE     | one-cycle done pulse, match valid
module tt_probe3 #(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       out,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       match,
    output logic       unstable
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE_W = 3'd1,
        SAMP_A   = 3'd2,
        SAMP_B   = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] rst_pipe;
    logic       rst_ok;
    logic [1:0] out_sync;
    logic       out_s;
    logic [2:0] row;
    logic [7:0] cnt;
    logic       a_bit;
    logic [7:0] exp_q;
    logic [7:0] tt_nxt;

    assign rst_ok = rst_pipe[1];
    assign out_s  = out_sync[1];

    // Assertion is immediate through rst_n; release takes effect two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sync <= 2'b00;
        end else if (!rst_ok) begin
            out_sync <= 2'b00;
        end else begin
            out_sync <= {out_sync[0], out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!rst_ok) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = SETTLE_W;
            SETTLE_W: if (cnt == 8'd0) state_nxt = SAMP_A;
            SAMP_A:   state_nxt = SAMP_B;
            SAMP_B:   state_nxt = (row == 3'd7) ? DONE : SETTLE_W;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE_W) || (state == SAMP_A) || (state == SAMP_B);
        done = (state == DONE);
        {in1, in2, in3} = busy ? row : 3'b000;
    end

    // Row r lands in bit 7-r, i.e. bit index ~r.
    always_comb begin
        tt_nxt       = tt;
        tt_nxt[~row] = out_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= 3'd0;
            cnt      <= 8'd0;
            a_bit    <= 1'b0;
            exp_q    <= 8'h00;
            tt       <= 8'h00;
            match    <= 1'b0;
            unstable <= 1'b0;
        end else if (!rst_ok) begin
            row      <= 3'd0;
            cnt      <= 8'd0;
            a_bit    <= 1'b0;
            exp_q    <= 8'h00;
            tt       <= 8'h00;
            match    <= 1'b0;
            unstable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q    <= expected;
                        tt       <= 8'h00;
                        match    <= 1'b0;
                        unstable <= 1'b0;
                        row      <= 3'd0;
                        cnt      <= CNT_LOAD;
                    end
                end
                SETTLE_W: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                SAMP_A: begin
                    a_bit <= out_s;
                end
                SAMP_B: begin
                    tt <= tt_nxt;
                    if (out_s != a_bit) unstable <= 1'b1;
                    // match is resolved here so it is already valid during DONE.
                    if (row == 3'd7) begin
                        match <= (tt_nxt == exp_q);
                    end else begin
                        row <= row + 3'd1;
                        cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
